// File: rtl/d_regfile_mp.sv
// Multi-port register file: NRD combinational read ports, two write ports (port 1 wins),
// optional hardwired-zero entry 0, debug tap and a sequential bulk-clear sweep.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module d_regfile_mp #(
    parameter int unsigned DW       = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned NRD      = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned TAP_IDX  = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*DW-1:0]   rdata,
    input  logic                we0,
    input  logic [AW-1:0]       wa0,
    input  logic [DW-1:0]       wd0,
    input  logic                we1,
    input  logic [AW-1:0]       wa1,
    input  logic [DW-1:0]       wd1,
    input  logic                clr_req,
    output logic                clr_busy,
    output logic                clr_done,
    output logic [DW-1:0]       tap
);

    localparam int unsigned     DEPTH = 1 << AW;
    localparam logic [AW-1:0]   TAP_A = AW'(TAP_IDX);
    localparam logic [AW-1:0]   LAST  = AW'(DEPTH - 1);
    localparam bit              ZR    = (ZERO_REG != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
        S_DONE
    } state_e;

    state_e         state_q;
    logic [AW-1:0]  ptr_q;
    logic           clr_busy_q;
    logic           clr_done_q;

    logic [DW-1:0]  mem_q [DEPTH];

    logic           wr0_ok;
    logic           wr1_ok;

    // Writes are dropped while the sweep owns the array, and never land on a hardwired zero.
    assign wr0_ok = we0 && !clr_busy_q && !(ZR && wa0 == '0);
    assign wr1_ok = we1 && !clr_busy_q && !(ZR && wa1 == '0);

    assign clr_busy = clr_busy_q;
    assign clr_done = clr_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    clr_done_q <= 1'b0;
                    if (clr_req) begin
                        state_q    <= S_SWEEP;
                        ptr_q      <= '0;
                        clr_busy_q <= 1'b1;
                    end
                end
                S_SWEEP: begin
                    ptr_q <= ptr_q + AW'(1);
                    if (ptr_q == LAST) begin
                        state_q    <= S_DONE;
                        clr_busy_q <= 1'b0;
                        clr_done_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q    <= S_IDLE;
                    clr_done_q <= 1'b0;
                end
                default: begin
                    state_q    <= S_IDLE;
                    clr_busy_q <= 1'b0;
                    clr_done_q <= 1'b0;
                end
            endcase
        end
    end

    // Port 1 is assigned last so it overrides port 0 on an address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clr_busy_q) begin
            mem_q[ptr_q] <= '0;
        end else begin
            if (wr0_ok) begin
                mem_q[wa0] <= wd0;
            end
            if (wr1_ok) begin
                mem_q[wa1] <= wd1;
            end
        end
    end

    function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        v = mem_q[a];
`ifdef REGFILE_BYPASS_EN
        if (wr1_ok && wa1 == a) begin
            v = wd1;
        end else if (wr0_ok && wa0 == a) begin
            v = wd0;
        end
`endif
        if (ZR && a == '0) begin
            v = '0;
        end
        return v;
    endfunction

    always_comb begin
        rdata = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            rdata[k*DW +: DW] = rd_val(ra[k*AW +: AW]);
        end
        tap = rd_val(TAP_A);
    end

endmodule

// File: tb/tb_d_regfile_mp.sv
// Bench for d_regfile_mp: directed vectors, a per-cycle model comparison and literal checks.
module tb_d_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;
    localparam int DEPTH = 32;
    localparam int TAP   = 10;

`ifdef REGFILE_BYPASS_EN
    localparam logic [31:0] BYP_SAME = 32'hCAFEF00D;
`else
    localparam logic [31:0] BYP_SAME = 32'h0000_0000;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NRD*AW-1:0]   ra = '0;
    logic [NRD*DW-1:0]   rdata;
    logic                we0 = 1'b0;
    logic [AW-1:0]       wa0 = '0;
    logic [DW-1:0]       wd0 = '0;
    logic                we1 = 1'b0;
    logic [AW-1:0]       wa1 = '0;
    logic [DW-1:0]       wd1 = '0;
    logic                clr_req = 1'b0;
    logic                clr_busy;
    logic                clr_done;
    logic [DW-1:0]       tap;

    int n_cmp = 0;
    int n_bad = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    d_regfile_mp #(
        .DW(DW), .AW(AW), .NRD(NRD), .ZERO_REG(1), .TAP_IDX(TAP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rdata(rdata),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done), .tap(tap)
    );

    // Model: array contents, cycles of sweep remaining, and the done pulse.
    logic [DW-1:0] m_mem [DEPTH];
    int            m_left = 0;
    bit            m_done = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            m_left = 0;
            m_done = 1'b0;
        end else if (m_left > 0) begin
            m_mem[DEPTH - m_left] = '0;
            m_left = m_left - 1;
            m_done = (m_left == 0);
        end else begin
            if (we0 && wa0 != 0) m_mem[wa0] = wd0;
            if (we1 && wa1 != 0) m_mem[wa1] = wd1;
            if (clr_req && !m_done) m_left = DEPTH;
            m_done = 1'b0;
        end
    end

    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (m_left == 0) begin
            if (we1 && wa1 == a) return wd1;
            if (we0 && wa0 == a) return wd0;
        end
`endif
        return m_mem[a];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            for (int k = 0; k < NRD; k++)
                check($sformatf("model_rdata%0d", k), rdata[k*DW +: DW], m_read(ra[k*AW +: AW]));
            check("model_tap", tap, m_read(AW'(TAP)));
            check("model_busy", {31'd0, clr_busy}, {31'd0, m_left > 0});
            check("model_done", {31'd0, clr_done}, {31'd0, m_done});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int  busy_cnt;
    int  done_cnt;
    bit  seen_done;
    bit  done_any;

    initial begin
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        checking = 1'b1;

        // Reset state on both ports and tap
        for (int a = 0; a < DEPTH; a++) begin
            ra = {AW'(a), AW'(a)};
            #1;
            check("rst_rd0", rdata[31:0], 32'h0);
            check("rst_rd1", rdata[63:32], 32'h0);
        end
        check("rst_tap", tap, 32'h0);
        check("rst_busy", {31'd0, clr_busy}, 32'h0);
        tick();

        // Basic write then read
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; ra = {5'd0, 5'd5};
        tick();
        we0 = 1'b0;
        #1 check("wr_dead", rdata[31:0], 32'hDEADBEEF);

        // Write to entry 0 is discarded
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'h12345678; ra = {5'd0, 5'd0};
        tick();
        we0 = 1'b0;
        #1 check("zero_rd0", rdata[31:0], 32'h0);
        check("zero_rd1", rdata[63:32], 32'h0);

        // Collision: port 1 wins
        we0 = 1'b1; we1 = 1'b1; wa0 = 5'd7; wa1 = 5'd7;
        wd0 = 32'h1111_1111; wd1 = 32'h2222_2222;
        tick();
        we0 = 1'b0; we1 = 1'b0; ra = {5'd7, 5'd7};
        #1 check("collide", rdata[31:0], 32'h2222_2222);

        // Tap follows entry TAP_IDX
        we1 = 1'b1; wa1 = 5'd10; wd1 = 32'h0000_00A5;
        tick();
        we1 = 1'b0;
        #1 check("tap_a5", tap, 32'h0000_00A5);

        // Same-cycle read of a write in flight
        tick();
        ra = {5'd4, 5'd0}; we1 = 1'b1; wa1 = 5'd4; wd1 = 32'hCAFEF00D;
        #1 check("byp_same", rdata[63:32], BYP_SAME);
        tick();
        we1 = 1'b0;
        #1 check("byp_next", rdata[63:32], 32'hCAFEF00D);

        // Fill every entry
        for (int a = 1; a < DEPTH; a++) begin
            we0 = 1'b1; wa0 = AW'(a); wd0 = 32'h100 + a;
            tick();
        end
        we0 = 1'b0; ra = {5'd31, 5'd3};
        #1 check("fill3", rdata[31:0], 32'h103);
        check("fill31", rdata[63:32], 32'h11F);

        // Bulk clear; the request cycle's write still commits
        clr_req = 1'b1; we0 = 1'b1; wa0 = 5'd12; wd0 = 32'hABCD0012;
        tick();
        clr_req = 1'b0; wa0 = 5'd3; wd0 = 32'h3333_3333; ra = {5'd3, 5'd12};
        #1 check("req_wr", rdata[31:0], 32'hABCD0012);
        busy_cnt = 0; done_cnt = 0; seen_done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (i == 5) clr_req = 1'b1;
            else if (i == 6) clr_req = 1'b0;
            if (clr_busy) busy_cnt++;
            if (clr_done) begin
                done_cnt++;
                seen_done = 1'b1;
                clr_req = 1'b1;
            end else if (seen_done && !clr_busy) begin
                clr_req = 1'b0;
                break;
            end
            if (!clr_busy) we0 = 1'b0;
            tick();
            #1;
        end
        we0 = 1'b0;
        check("busy_cycles", busy_cnt, 32'd32);
        check("done_pulses", done_cnt, 32'd1);
        tick();
        #1 check("no_resweep", {31'd0, clr_busy}, 32'h0);
        for (int a = 0; a < DEPTH; a++) begin
            ra = {AW'(a), AW'(a)};
            #1;
            check("swept_rd0", rdata[31:0], 32'h0);
            check("swept_rd1", rdata[63:32], 32'h0);
        end
        tick();

        // Reset during a sweep aborts it without a done pulse
        we0 = 1'b1; wa0 = 5'd10; wd0 = 32'h0000_00A5;
        we1 = 1'b1; wa1 = 5'd20; wd1 = 32'h0000_0077;
        tick();
        we0 = 1'b0; we1 = 1'b0; clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (10) tick();
        ra = {5'd20, 5'd25};
        #1 check("pre_rst_rd1", rdata[63:32], 32'h0000_0077);
        rst_n = 1'b0;
        #1 check("arst_busy", {31'd0, clr_busy}, 32'h0);
        check("arst_done", {31'd0, clr_done}, 32'h0);
        check("arst_rd1", rdata[63:32], 32'h0);
        check("arst_tap", tap, 32'h0);
        done_any = 1'b0;
        tick();
        done_any |= clr_done;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            #1 done_any |= clr_done;
        end
        check("no_done_after_abort", {31'd0, done_any}, 32'h0);
        check("idle_after_abort", {31'd0, clr_busy}, 32'h0);

        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
